// File: rtl/dsep_frame_ctrl_pkg.sv
// Shared types and default frame geometry for the DSEP frame controller.
// Lengths are derived from the OFDM symbol layout so that one edit keeps them consistent.
package dsep_frame_ctrl_pkg;

   localparam int SMP_W = 12;
   localparam int IDX_W = 10;
   localparam int CNT_W = 13;

   localparam int N       = 512;
   localparam int CP_LEN  = 32;
   localparam int PRB_NUM = 8;
   localparam int MAX_NUM = 10;

   localparam int FILL_LEN_D   = 8192;
   localparam int PRB_LEN_D    = N * (PRB_NUM - 1) - N;
   localparam int SIGPLD_LEN_D = (N + CP_LEN) * (MAX_NUM - 3);
   localparam int TIMEOUT_D    = 16383;
   localparam int GAP_D        = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

endpackage

// File: rtl/dsep_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module dsep_sat_cnt #(
   parameter int             W   = 8,
   parameter logic [W-1:0]   MAX = '1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = cnt;
      if (clr)
         cnt_nxt = '0;
      else if (en && (cnt != MAX))
         cnt_nxt = cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else
         cnt <= cnt_nxt;
   end

endmodule

// File: rtl/dsep_frame_ctrl.sv
// Frame gate and watchdog around DSEP: admits one frame of samples, forwards the
// first sync index, tracks DSEP output completion and resets DSEP on failure.
module dsep_frame_ctrl
   import dsep_frame_ctrl_pkg::*;
#(
   parameter int FILL_LEN   = FILL_LEN_D,
   parameter int PRB_LEN    = PRB_LEN_D,
   parameter int SIGPLD_LEN = SIGPLD_LEN_D,
   parameter int TIMEOUT    = TIMEOUT_D,
   parameter int GAP        = GAP_D
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    frame_start,
   input  logic signed [SMP_W-1:0] di_re,
   input  logic signed [SMP_W-1:0] di_im,
   input  logic                    di_vld,
   input  logic        [IDX_W-1:0] max_indx,
   input  logic                    max_indx_vld,
   input  logic                    dsep_preamble_vld,
   input  logic                    dsep_sigpld_vld,
   output logic signed [SMP_W-1:0] do_re,
   output logic signed [SMP_W-1:0] do_im,
   output logic                    do_vld,
   output logic        [IDX_W-1:0] do_max_indx,
   output logic                    do_max_indx_vld,
   output logic                    dsep_rst,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    err_nosync,
   output logic                    err_timeout,
   output logic        [15:0]      drop_cnt,
   output logic        [7:0]       miss_cnt
);

   localparam int FC_W = $clog2(FILL_LEN + 1);
   localparam int TM_W = $clog2(TIMEOUT + 1);
   localparam int GP_W = $clog2(GAP + 1);

   localparam logic [FC_W-1:0]  FILL_LAST = FC_W'(FILL_LEN - 1);
   localparam logic [TM_W-1:0]  TM_LAST   = TM_W'(TIMEOUT - 1);
   localparam logic [GP_W-1:0]  GP_LAST   = GP_W'(GAP - 1);
   localparam logic [CNT_W-1:0] PRB_MAX   = CNT_W'(PRB_LEN);
   localparam logic [CNT_W-1:0] SP_MAX    = CNT_W'(SIGPLD_LEN);

   state_t           state, state_nxt;
   logic [FC_W-1:0]  fill_cnt;
   logic [TM_W-1:0]  timer;
   logic [GP_W-1:0]  gap_cnt;
   logic             sync_seen;
   logic [CNT_W-1:0] prb_cnt, sp_cnt;

   logic start, acc, last, sync_hit, synced;
   logic prb_full, sp_full;
   logic done_nxt, nosync_nxt, tmo_nxt;

   assign start    = (state == ST_IDLE) && frame_start;
   assign acc      = (state == ST_FILL) && di_vld;
   assign last     = acc && (fill_cnt == FILL_LAST);
   assign sync_hit = (state == ST_FILL) && max_indx_vld && !sync_seen;
   assign synced   = sync_seen || max_indx_vld;

   // Look one increment ahead so a valid landing on the final count completes now.
   assign prb_full = (prb_cnt == PRB_MAX) || (dsep_preamble_vld && (prb_cnt == PRB_MAX - 1'b1));
   assign sp_full  = (sp_cnt == SP_MAX) || (dsep_sigpld_vld && (sp_cnt == SP_MAX - 1'b1));

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (frame_start) state_nxt = ST_FILL;
         ST_FILL:  if (last) state_nxt = synced ? ST_DRAIN : ST_FLUSH;
         ST_DRAIN: if (done_nxt || tmo_nxt) state_nxt = ST_FLUSH;
         ST_FLUSH: if (gap_cnt == GP_LAST) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Completion beats timeout when both land on the same cycle.
   always_comb begin
      done_nxt   = 1'b0;
      nosync_nxt = 1'b0;
      tmo_nxt    = 1'b0;
      unique case (state)
         ST_FILL:  nosync_nxt = last && !synced;
         ST_DRAIN: begin
            done_nxt = prb_full && sp_full;
            tmo_nxt  = !done_nxt && (timer == TM_LAST);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_done  <= 1'b0;
         err_nosync  <= 1'b0;
         err_timeout <= 1'b0;
         dsep_rst    <= 1'b0;
      end else begin
         frame_done  <= done_nxt;
         err_nosync  <= nosync_nxt;
         err_timeout <= tmo_nxt;
         dsep_rst    <= nosync_nxt || tmo_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         do_re           <= '0;
         do_im           <= '0;
         do_vld          <= 1'b0;
         do_max_indx     <= '0;
         do_max_indx_vld <= 1'b0;
      end else begin
         do_vld          <= acc;
         do_max_indx_vld <= sync_hit;
         if (acc) begin
            do_re <= di_re;
            do_im <= di_im;
         end
         if (sync_hit)
            do_max_indx <= max_indx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_cnt  <= '0;
         sync_seen <= 1'b0;
         timer     <= '0;
         gap_cnt   <= '0;
      end else begin
         if (start) begin
            fill_cnt  <= '0;
            sync_seen <= 1'b0;
         end else begin
            if (acc)      fill_cnt  <= fill_cnt + 1'b1;
            if (sync_hit) sync_seen <= 1'b1;
         end
         timer   <= (state == ST_DRAIN) ? timer + 1'b1 : '0;
         gap_cnt <= (state == ST_FLUSH) ? gap_cnt + 1'b1 : '0;
      end
   end

   dsep_sat_cnt #(.W(16)) u_drop (
      .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(di_vld && !acc), .cnt(drop_cnt)
   );

   dsep_sat_cnt #(.W(8)) u_miss (
      .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(frame_start && busy), .cnt(miss_cnt)
   );

   dsep_sat_cnt #(.W(CNT_W), .MAX(PRB_MAX)) u_prb (
      .clk(clk), .rst_n(rst_n), .clr(start),
      .en((state == ST_DRAIN) && dsep_preamble_vld), .cnt(prb_cnt)
   );

   dsep_sat_cnt #(.W(CNT_W), .MAX(SP_MAX)) u_sp (
      .clk(clk), .rst_n(rst_n), .clr(start),
      .en((state == ST_DRAIN) && dsep_sigpld_vld), .cnt(sp_cnt)
   );

endmodule
